reg_file_sb: RTL

- Next-generation architectural register file for the RV32 core.
- Generalised to N read ports, with x0 hardwired to zero and same-cycle write-to-read forwarding.
- Synchronous reset triggers a sequential clear sweep across all entries.
- Built-in scoreboard of pending-write bits lets decode detect RAW hazards without an external table.
- Sits between decode (reads, issue) and writeback (write).

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 42 ++++
 rtl/reg_file_sb.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the RV32 register file and its scoreboard.
package reg_file_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_WORD_W = 32;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_WORD_W-1:0] word_t;

  // Architectural index of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, queried combinationally by every read port.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDR_W,
  parameter int NUM_READ      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_en,
  input  logic [ADDRESS_WIDTH-1:0]          set_addr,
  input  logic                              clr_en,
  input  logic [ADDRESS_WIDTH-1:0]          clr_addr,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] q_addr,
  output logic [NUM_READ-1:0]               q_pend
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0] pend;

  // Clear first, then set, so a new producer issued in the same cycle as the
  // old one's writeback keeps the register marked pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en && (set_addr != ZERO_ADDR)) pend[set_addr] <= 1'b1;
    end
  end

  // A writeback landing this cycle already resolves the hazard for the reader.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_query
    logic [ADDRESS_WIDTH-1:0] qa;
    assign qa        = q_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign q_pend[i] = pend[qa] && !(clr_en && (clr_addr == qa));
  end

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with N forwarded read ports, hardwired x0,
// a post-reset clear sweep and a built-in pending-write scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WORD_WIDTH    = RF_WORD_W,
  parameter int ADDRESS_WIDTH = RF_ADDR_W,
  parameter int NUM_READ      = 2,
  parameter int DEBUG_REG     = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] RA,
  output logic [NUM_READ*WORD_WIDTH-1:0]    RD,
  output logic [NUM_READ-1:0]               PEND,
  input  logic [ADDRESS_WIDTH-1:0]          WA3,
  input  logic [WORD_WIDTH-1:0]             WD3,
  input  logic                              WEN,
  input  logic                              ISSUE_EN,
  input  logic [ADDRESS_WIDTH-1:0]          ISSUE_ADDR,
  output logic                              busy,
  output logic [WORD_WIDTH-1:0]             a0
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [ADDRESS_WIDTH-1:0] DBG_ADDR  = ADDRESS_WIDTH'(DEBUG_REG);

  rf_state_t                state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] cnt, cnt_nxt;
  logic [WORD_WIDTH-1:0]    mem [DEPTH];
  logic                     wr_ok;
  logic [NUM_READ-1:0]      sb_pend;

  assign busy  = (state == RF_CLEAR);
  assign wr_ok = WEN && !busy;

  // Sweep state register; reset always restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep walks every entry once; the counter wraps to 0 as it returns to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == RF_CLEAR) begin
      cnt_nxt = cnt + ADDRESS_WIDTH'(1);
      if (cnt == '1) state_nxt = RF_IDLE;
    end
  end

  // Storage: sweep clears one entry per cycle, otherwise writeback stores.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[cnt] <= '0;
    end else if (WEN && (WA3 != ZERO_ADDR)) begin
      mem[WA3] <= WD3;
    end
  end

  // Zero-latency read ports with same-cycle writeback forwarding.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] ra;
    assign ra = RA[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign RD[i*WORD_WIDTH +: WORD_WIDTH] =
      (busy || (ra == ZERO_ADDR)) ? '0 :
      (WEN && (WA3 == ra))        ? WD3 : mem[ra];
    assign PEND[i] = !busy && sb_pend[i];
  end

  // Debug tap follows the same rule as the read ports.
  assign a0 = (busy || (DBG_ADDR == ZERO_ADDR)) ? '0 :
              (WEN && (WA3 == DBG_ADDR))        ? WD3 : mem[DBG_ADDR];

  reg_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_READ     (NUM_READ)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (ISSUE_EN && !busy),
    .set_addr(ISSUE_ADDR),
    .clr_en  (wr_ok),
    .clr_addr(WA3),
    .q_addr  (RA),
    .q_pend  (sb_pend)
  );

endmodule
